// File: rtl/alu_flag_stage.sv
// Execute-stage back end: holds the NZCV flag register, evaluates the condition
// field against it, and registers the ALU result for the writeback cycle.
module alu_flag_stage #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] alu_result,
  input  logic         alu_co,
  input  logic         alu_ovf,
  input  logic         alu_z,
  input  logic         alu_n,
  input  logic [2:0]   alu_ctrl,
  input  logic         shifter_carry,
  input  logic         ex_valid,
  input  logic [3:0]   cond,
  input  logic         s_bit,
  input  logic         msr_we,
  input  logic [3:0]   msr_nzcv,
  output logic [3:0]   nzcv,
  output logic         cond_pass,
  output logic [W-1:0] alu_out_q,
  output logic         result_valid,
  output logic         cond_fail
);

  logic [3:0]   nzcv_q, nzcv_d;
  logic [W-1:0] alu_out_d;
  logic         result_valid_q, result_valid_d;
  logic         cond_fail_q, cond_fail_d;
  logic         flag_n, flag_z, flag_c, flag_v;

  assign {flag_n, flag_z, flag_c, flag_v} = nzcv_q;

  // Decode uses only the registered flags, so a flag-setting op is seen by the
  // instruction in the following execute cycle, never by itself.
  always_comb begin
    cond_pass = 1'b0;
    unique case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    nzcv_d         = nzcv_q;
    alu_out_d      = alu_out_q;
    result_valid_d = 1'b0;
    cond_fail_d    = 1'b0;
    if (ex_valid) begin
      if (cond_pass) begin
        alu_out_d      = alu_result;
        result_valid_d = 1'b1;
        if (s_bit) begin
          // Logical ops take C from the shifter and leave V untouched.
          if (alu_ctrl[2]) nzcv_d = {alu_n, alu_z, shifter_carry, nzcv_q[0]};
          else             nzcv_d = {alu_n, alu_z, alu_co, alu_ovf};
        end
      end else begin
        cond_fail_d = 1'b1;
      end
    end
    // Direct flag write overrides any ALU flag update in the same cycle.
    if (msr_we) nzcv_d = msr_nzcv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv_q         <= 4'b0000;
      alu_out_q      <= '0;
      result_valid_q <= 1'b0;
      cond_fail_q    <= 1'b0;
    end else begin
      nzcv_q         <= nzcv_d;
      alu_out_q      <= alu_out_d;
      result_valid_q <= result_valid_d;
      cond_fail_q    <= cond_fail_d;
    end
  end

  assign nzcv         = nzcv_q;
  assign result_valid = result_valid_q;
  assign cond_fail    = cond_fail_q;

endmodule

// File: tb/tb_alu_flag_stage.sv
// Randomized and directed self-checking bench for alu_flag_stage against a
// behavioural model of the flag register and condition evaluation.
module tb_alu_flag_stage;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] alu_result;
  logic         alu_co, alu_ovf, alu_z, alu_n;
  logic [2:0]   alu_ctrl;
  logic         shifter_carry, ex_valid, s_bit, msr_we;
  logic [3:0]   cond, msr_nzcv;
  logic [3:0]   nzcv;
  logic         cond_pass;
  logic [W-1:0] alu_out_q;
  logic         result_valid, cond_fail;

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [3:0]   m_nzcv;
  logic [W-1:0] m_out;
  logic         m_rv, m_cf;

  alu_flag_stage #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .alu_result(alu_result), .alu_co(alu_co),
    .alu_ovf(alu_ovf), .alu_z(alu_z), .alu_n(alu_n), .alu_ctrl(alu_ctrl),
    .shifter_carry(shifter_carry), .ex_valid(ex_valid), .cond(cond),
    .s_bit(s_bit), .msr_we(msr_we), .msr_nzcv(msr_nzcv), .nzcv(nzcv),
    .cond_pass(cond_pass), .alu_out_q(alu_out_q),
    .result_valid(result_valid), .cond_fail(cond_fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ARM condition codes come in pairs: the odd code is the negation of the even one.
  function automatic logic ref_pass(input logic [3:0] f, input logic [3:0] c);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return base ^ c[0];
  endfunction

  task automatic idle();
    alu_result = '0; alu_co = 0; alu_ovf = 0; alu_z = 0; alu_n = 0;
    alu_ctrl = 3'b000; shifter_carry = 0; ex_valid = 0; cond = 4'b1110;
    s_bit = 0; msr_we = 0; msr_nzcv = 4'b0000;
  endtask

  task automatic model_reset();
    m_nzcv = 4'b0000; m_out = '0; m_rv = 0; m_cf = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".nzcv"}, nzcv, m_nzcv);
    check({tag, ".out"}, alu_out_q, m_out);
    check({tag, ".rv"}, result_valid, m_rv);
    check({tag, ".cf"}, cond_fail, m_cf);
    check({tag, ".pass"}, cond_pass, ref_pass(m_nzcv, cond));
  endtask

  // One clock: update the model with the inputs present at the edge, then compare at negedge.
  task automatic cycle(input string tag);
    logic pass;
    @(posedge clk);
    pass = ref_pass(m_nzcv, cond);
    m_rv = 0; m_cf = 0;
    if (ex_valid) begin
      if (pass) begin
        m_out = alu_result;
        m_rv = 1;
        if (s_bit)
          m_nzcv = alu_ctrl[2] ? {alu_n, alu_z, shifter_carry, m_nzcv[0]}
                               : {alu_n, alu_z, alu_co, alu_ovf};
      end else begin
        m_cf = 1;
      end
    end
    if (msr_we) m_nzcv = msr_nzcv;
    @(negedge clk);
    check_outputs(tag);
    $display("txn %s: ex=%0b cond=%h nzcv=%b out=%h rv=%0b cf=%0b",
             tag, ex_valid, cond, nzcv, alu_out_q, result_valid, cond_fail);
  endtask

  task automatic set_flags(input logic [3:0] v);
    idle(); msr_we = 1; msr_nzcv = v;
    cycle("msr");
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst_n = 1;

    // Arithmetic flag set
    idle(); ex_valid = 1; cond = 4'b1110; s_bit = 1; alu_ctrl = 3'b000;
    alu_result = 4'b1000; alu_n = 1; alu_z = 0; alu_co = 0; alu_ovf = 1;
    cycle("arith");
    check("arith.nzcv_c", nzcv, 4'b1001);
    check("arith.out_c", alu_out_q, 4'b1000);
    check("arith.rv_c", result_valid, 1'b1);
    idle(); cond = 4'b1011; #1 check("arith.lt", cond_pass, 1'b0);
    cond = 4'b1010; #1 check("arith.ge", cond_pass, 1'b1);
    cycle("arith_idle");
    check("arith.rv_pulse", result_valid, 1'b0);

    // Logical op keeps V
    idle(); ex_valid = 1; cond = 4'b1110; s_bit = 1; alu_ctrl = 3'b100;
    alu_result = 4'b0000; alu_z = 1; alu_n = 0; shifter_carry = 1; alu_ovf = 0;
    cycle("logic");
    check("logic.nzcv_c", nzcv, 4'b0111);

    // Condition fail
    set_flags(4'b0100);
    ex_valid = 1; cond = 4'b0001; s_bit = 1; alu_result = 4'b0101;
    alu_n = 1; alu_co = 1; alu_ovf = 1;
    cycle("cfail");
    check("cfail.cf_c", cond_fail, 1'b1);
    check("cfail.rv_c", result_valid, 1'b0);
    check("cfail.nzcv_c", nzcv, 4'b0100);
    check("cfail.out_c", alu_out_q, 4'b0000);
    idle(); cycle("cfail_idle");
    check("cfail.cf_pulse", cond_fail, 1'b0);

    // MSR priority over ALU flag update
    idle(); ex_valid = 1; cond = 4'b1110; s_bit = 1; alu_result = 4'b0110;
    msr_we = 1; msr_nzcv = 4'b1010;
    cycle("msr_prio");
    check("msr_prio.nzcv_c", nzcv, 4'b1010);
    check("msr_prio.out_c", alu_out_q, 4'b0110);
    check("msr_prio.rv_c", result_valid, 1'b1);

    // Full condition sweep
    for (int f = 0; f < 16; f++) begin
      set_flags(f[3:0]);
      for (int c = 0; c < 16; c++) begin
        cond = c[3:0];
        #1 check($sformatf("sweep.f%0h.c%0h", f, c), cond_pass, ref_pass(f[3:0], c[3:0]));
        if (c == 15) check("sweep.nv", cond_pass, 1'b0);
      end
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      alu_result = W'($urandom);
      {alu_co, alu_ovf, alu_z, alu_n, shifter_carry} = 5'($urandom);
      alu_ctrl = 3'($urandom);
      ex_valid = ($urandom_range(0, 1) == 1);
      cond = 4'($urandom);
      s_bit = ($urandom_range(0, 3) != 0);
      msr_we = ($urandom_range(0, 7) == 0);
      msr_nzcv = 4'($urandom);
      cycle("rand");
    end

    // Asynchronous reset mid-cycle
    idle(); ex_valid = 1; s_bit = 1; alu_result = 4'b1111; alu_n = 1; alu_co = 1;
    cycle("pre_rst");
    @(posedge clk);
    #2 rst_n = 0;
    cond = 4'b0001;
    #1;
    model_reset();
    check("arst.nzcv", nzcv, 4'b0000);
    check("arst.out", alu_out_q, 4'b0000);
    check("arst.rv", result_valid, 1'b0);
    check("arst.cf", cond_fail, 1'b0);
    check("arst.ne", cond_pass, 1'b1);
    @(negedge clk);
    check_outputs("arst_hold");
    rst_n = 1;
    idle();
    cycle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_flag_stage.md
Name: alu_flag_stage

Overview:
- Execute-stage back end of the multi-cycle datapath; sits directly downstream of the ALU.
- Consumes the ALU result and its combinational CO/OVF/Z/N outputs.
- Holds the architectural NZCV flag register and evaluates the ARM 4-bit condition field against it.
- Registers the ALU result (ALUOut) for the writeback cycle and reports per-instruction pass/fail to the control FSM.

Parameters:
W, 4, datapath width; must match the ALU W.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
alu_result  input  W  ALU out
alu_co  input  1  ALU carry flag
alu_ovf  input  1  ALU overflow flag
alu_z  input  1  ALU zero flag
alu_n  input  1  ALU negative flag
alu_ctrl  input  3  ALU_Control of the current op; bit2=1 means logical op
shifter_carry  input  1  shifter carry-out; used as C for logical ops
ex_valid  input  1  execute cycle active; one-cycle strobe from control FSM
cond  input  4  instruction condition field [31:28]
s_bit  input  1  instruction sets flags
msr_we  input  1  direct flag write (MSR / exception return)
msr_nzcv  input  4  flag value for direct write, {N,Z,C,V}
nzcv  output  4  flag register {N,Z,C,V}
cond_pass  output  1  combinational: cond evaluated against current nzcv
alu_out_q  output  W  registered ALU result
result_valid  output  1  one-cycle pulse: alu_out_q holds a passed result
cond_fail  output  1  one-cycle pulse: the last ex_valid op failed its condition

Behaviour:
- Reset (async, rst_n=0): nzcv=4'b0000, alu_out_q=0, result_valid=0, cond_fail=0. All registers hold at 0 while rst_n is low.
- cond_pass decode (combinational from the nzcv register, never from the alu_* inputs):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 treated as never (0).
- Rising edge with ex_valid=1 and cond_pass=1:
  - alu_out_q <= alu_result.
  - result_valid <= 1, cond_fail <= 0.
  - If s_bit=1 and msr_we=0:
    - arithmetic op (alu_ctrl[2]=0): nzcv <= {alu_n, alu_z, alu_co, alu_ovf}.
    - logical op (alu_ctrl[2]=1): nzcv <= {alu_n, alu_z, shifter_carry, V unchanged}.
- Rising edge with ex_valid=1 and cond_pass=0:
  - alu_out_q holds, nzcv holds.
  - result_valid <= 0, cond_fail <= 1.
- Rising edge with ex_valid=0:
  - result_valid <= 0, cond_fail <= 0.
  - alu_out_q and nzcv hold, except for msr_we.
- msr_we=1 (any cycle): nzcv <= msr_nzcv.
  - Takes priority over a simultaneous ALU flag update.
  - Independent of ex_valid and cond; alu_out_q capture is unaffected.
- Latency:
  - New flags are visible on nzcv and cond_pass one cycle after the updating edge.
  - Back-to-back ex_valid cycles therefore see the previous op's flags (required for ADDS followed by BEQ in the next cycle).
- result_valid and cond_fail are mutually exclusive and never high for more than one cycle per ex_valid strobe.
- Reset asserted mid-operation clears everything immediately. There is no pending state to recover.
- Widths: alu_result is taken unmodified. No sign or zero extension.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle -> nzcv=0000, alu_out_q=0, result_valid=0, cond_fail=0 immediately. cond=0001 (NE) -> cond_pass=1.
- Arithmetic set: ex_valid=1, cond=1110, s_bit=1, alu_ctrl=000, alu_result=4'b1000, n=1 z=0 co=0 ovf=1 -> next cycle nzcv=1001, alu_out_q=1000, result_valid pulse. Then cond=1011 (LT) -> cond_pass=0; cond=1010 (GE) -> cond_pass=1.
- Logical keeps V: with nzcv=1001, ex_valid=1, s_bit=1, alu_ctrl=100, alu_result=0000, z=1 n=0, shifter_carry=1 -> nzcv=0111.
- Condition fail: nzcv=0100, cond=0001 (NE), ex_valid=1, s_bit=1, alu_result=0101 -> cond_fail pulse, alu_out_q and nzcv unchanged, result_valid=0.
- MSR priority: same cycle ex_valid=1, cond=1110, s_bit=1 (ALU flags 0000) and msr_we=1, msr_nzcv=1010 -> nzcv=1010, alu_out_q updated, result_valid=1.
- Cond 1111 and sweep: for all 16 nzcv values × 16 cond codes, check cond_pass against the decode table. cond=1111 -> 0 always.
